cla_pipe_adder: RTL

- Parametrised, pipelined carry-lookahead adder; next generation of the team's 32-bit combinational CLA adder.
- WIDTH-bit operands are split into STAGES equal slices. Each slice is a 4-bit-group CLA; the carry between slices is registered.
- A valid/ready handshake on input and output supports back-pressure.
- Adds signed-overflow and zero flags.
- Sits between datapath register stages wherever a full-width combinational CLA misses timing.

---
 rtl/cla_pkg.sv | 32 +++
 rtl/cla_slice.sv | 63 ++++++
 rtl/cla_pipe_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned GROUP_DEFAULT = 4;
    localparam int unsigned GROUP_MAX     = 8;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // Group generate/propagate over the low n bits of g/p.
    function automatic gp_t group_gp(input logic [GROUP_MAX-1:0] g,
                                     input logic [GROUP_MAX-1:0] p,
                                     input int unsigned n);
        gp_t r;
        r.g = 1'b0;
        r.p = 1'b1;
        for (int unsigned i = 0; i < GROUP_MAX; i++) begin
            if (i < n) begin
                r.g = g[i] | (p[i] & r.g);
                r.p = r.p & p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SW-bit adder: per-group generate/propagate, lookahead across groups.
module cla_slice
    import cla_pkg::*;
#(
    parameter int unsigned SW    = 16,
    parameter int unsigned GROUP = GROUP_DEFAULT
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    localparam int unsigned NG = SW / GROUP;

    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gpr;
    logic [NG:0]   cg;
    gp_t           t;
    logic          acc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg  = '0;
        gpr = '0;
        cg  = '0;
        c   = '0;
        t   = '0;
        acc = 1'b0;
        for (int unsigned j = 0; j < NG; j++) begin
            t      = group_gp(GROUP_MAX'(g[j*GROUP +: GROUP]), GROUP_MAX'(p[j*GROUP +: GROUP]), GROUP);
            gg[j]  = t.g;
            gpr[j] = t.p;
        end
        // Each group carry is a flat sum-of-products of group G/P terms and ci.
        for (int unsigned j = 0; j <= NG; j++) begin
            acc = ci;
            for (int unsigned m = 0; m < j; m++) begin
                acc = gg[m] | (gpr[m] & acc);
            end
            cg[j] = acc;
        end
        for (int unsigned i = 0; i < SW; i++) begin
            acc = cg[i / GROUP];
            for (int unsigned m = (i / GROUP) * GROUP; m < i; m++) begin
                acc = g[m] | (p[m] & acc);
            end
            c[i] = acc;
        end
    end

    assign s     = p ^ c;
    assign co    = cg[NG];
    assign c_msb = c[SW-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder: STAGES slices with registered inter-slice carries and valid/ready flow control.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned GROUP  = GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > 8 || GROUP < 1 || GROUP > GROUP_MAX ||
        (WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP, STAGES in 1..8");
    end

    logic advance;

    // Whole pipeline moves together; only the output handshake can stall it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int unsigned IW = WIDTH - k * SW;
        localparam int unsigned DW = (k + 1) * SW;

        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [SW-1:0] s_sl;
        logic          co_sl;
        logic          msb_sl;
        logic [DW-1:0] s_next;
        logic          v_r;
        logic          c_r;
        logic [DW-1:0] s_r;

        if (k == 0) begin : g_first
            assign a_in   = a;
            assign b_in   = b;
            assign c_in   = cin;
            assign v_in   = in_valid;
            assign s_next = s_sl;
        end else begin : g_next
            assign a_in   = stg[k-1].g_hi.a_hi;
            assign b_in   = stg[k-1].g_hi.b_hi;
            assign c_in   = stg[k-1].c_r;
            assign v_in   = stg[k-1].v_r;
            assign s_next = {s_sl, stg[k-1].s_r};
        end

        cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
            .a     (a_in[SW-1:0]),
            .b     (b_in[SW-1:0]),
            .ci    (c_in),
            .s     (s_sl),
            .co    (co_sl),
            .c_msb (msb_sl)
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_in;
                c_r <= co_sl;
                s_r <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_hi
            logic [IW-SW-1:0] a_hi;
            logic [IW-SW-1:0] b_hi;
            logic             unused_msb;

            assign unused_msb = msb_sl;

            // Operand bits not yet added travel with the partial sum.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (advance) begin
                    a_hi <= a_in[IW-1:SW];
                    b_hi <= b_in[IW-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_r;
            logic zero_r;

            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (advance) begin
                    ovf_r  <= msb_sl ^ co_sl;
                    zero_r <= (s_next == '0);
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_r;
    assign sum       = stg[STAGES-1].s_r;
    assign cout      = stg[STAGES-1].c_r;
    assign ovf       = stg[STAGES-1].g_last.ovf_r;
    assign zero      = stg[STAGES-1].g_last.zero_r;

endmodule
